rrc_fir_serial: RTL and testbench
=================================

# rrc_fir_serial

Parametrised, time-multiplexed RRC/FIR filter that replaces the fixed 33-tap, fully parallel filter with a single multiply-accumulate engine. It adds run-time loadable coefficients, a valid/ready input handshake, round-half-up output scaling and a saturation flag. It sits in the same transmit/receive pulse-shaping path, between the symbol source and the DAC/decision stage. It trades throughput (one sample per TAPS+2 cycles) for one multiplier.

## Interface
- DATA_W, 9: signed input sample width
- COEF_W, 9: signed coefficient width
- TAPS, 33: number of taps; delay-line depth
- ACC_W, 24: signed accumulator width; must be >= DATA_W+COEF_W+$clog2(TAPS), else elaboration error
- FRAC_SH, 8: fractional bits removed from the accumulator before output
- OUT_W, 9: signed output width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a sample (combinational, high only in IDLE)
- in_data  in  DATA_W  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index; 0 multiplies the newest sample
- coef_wdata  in  COEF_W  signed coefficient value
- out_valid  out  1  one-cycle pulse, out_data/sat_flag valid
- out_data  out  OUT_W  signed filtered sample
- sat_flag  out  1  out_data was clipped (valid with out_valid)
- busy  out  1  high in MAC or DONE

## Operation
- Clock `clk`, reset `rst_n`: one clock domain, asynchronous active-low reset.
- Reset clears: delay line to 0, all coefficients to 0, acc 0, tap index 0, state IDLE, out_data 0, out_valid 0, sat_flag 0. in_ready is 1 while reset is deasserted in IDLE.
- States: IDLE, MAC, DONE.
- IDLE: in_ready=1. On in_valid && in_ready at a clock edge:
  - shift the delay line (d[0]<=in_data, d[k]<=d[k-1]);
  - set acc<=0 and idx<=0;
  - go to MAC.
- MAC: every cycle acc <= acc + d[idx]*coef[idx] (full-precision signed product, sign-extended to ACC_W), then idx++. When idx==TAPS-1, go to DONE.
- DONE: register the output and return to IDLE.
  - r = (acc + 2^(FRAC_SH-1)) >>> FRAC_SH (round half up, arithmetic shift).
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat_flag=1 iff clipped.
  - out_valid=1 for exactly one cycle.
- Coefficient write: applied at the edge when coef_we=1, state==IDLE, and coef_addr<TAPS. Dropped in MAC/DONE or when the address is out of range.
- Write and sample accepted on the same edge: the new coefficient is used for that sample.
- No output backpressure; the consumer must take out_data on the out_valid pulse. out_data holds its value until the next DONE.
- Reset mid-operation (any state): immediate return to reset values. The pending output is discarded and out_valid does not pulse.

## Timing
- Accept edge E0.
- MAC accumulates on edges E1..E_TAPS, then enters DONE.
- Edge E_TAPS+1: out_data/sat_flag registered, out_valid=1, state IDLE, in_ready=1.
- Latency: accept edge to out_valid high is TAPS+1 edges (34 at defaults).
- Next accept possible at E_TAPS+2, giving a maximum rate of 1 sample / (TAPS+2) cycles.
- in_ready is low from after E0 until after E_TAPS+1. A held in_valid is not consumed during that window.

## Test plan
1. Reset/zero coefficients: rst_n low 5 cycles, then release.
   - Check out_data=0, out_valid=0, sat_flag=0, in_ready=1.
   - Push in_data=100 -> out_valid after 34 edges with out_data=0.
2. Impulse response: load coef[k]=4k-64 (k=0..32), push 64 then 40 zeros.
   - n-th output = n-16 for n=0..32 (i.e. -16..16), then 0.
   - sat_flag always 0.
3. Rounding: coef[0]=1, others 0.
   - Inputs 128, 127, -128, -129 -> outputs 1, 0, 0, -1.
4. Saturation: all coef=255.
   - 33 inputs of 255 -> final output 255, sat_flag=1.
   - Then 33 inputs of -256 -> -256, sat_flag=1.
5. Handshake/rate: in_valid held high with an incrementing in_data.
   - Exactly one accept every 35 cycles; in_ready low for 34 cycles after each accept.
   - No sample skipped or duplicated.
   - coef_we during MAC does not change coefficients (verify by re-running test 2).
6. Reset mid-MAC: assert rst_n at MAC cycle 10.
   - No out_valid pulse; out_data=0; coefficients read back 0 (impulse gives 0); in_ready=1 after release.

Source files
------------

// File: rtl/rrc_fir_serial.sv
// Time-multiplexed FIR/RRC filter, one MAC per tap; output TAPS+1 edges after accept.
// Backpressure: in_ready is high only in IDLE; output has no backpressure (single-cycle pulse).
module rrc_fir_serial #(
  parameter int DATA_W  = 9,
  parameter int COEF_W  = 9,
  parameter int TAPS    = 33,
  parameter int ACC_W   = 24,
  parameter int FRAC_SH = 8,
  parameter int OUT_W   = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic                      out_valid,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      sat_flag,
  output logic                      busy
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;
  localparam int RW = ACC_W + 1;

  localparam logic [AW:0]            TAPS_C  = (AW+1)'(TAPS);
  localparam logic [AW-1:0]          LAST    = AW'(TAPS - 1);
  localparam logic signed [RW-1:0]   HALF    = RW'(1 << (FRAC_SH - 1));
  localparam logic signed [RW-1:0]   OUT_MAX = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0]   OUT_MIN = ~OUT_MAX;

  if (ACC_W < DATA_W + COEF_W + $clog2(TAPS)) begin : g_acc_chk
    $error("rrc_fir_serial: ACC_W too narrow for DATA_W+COEF_W+clog2(TAPS)");
  end
  if (TAPS < 2 || FRAC_SH < 1) begin : g_par_chk
    $error("rrc_fir_serial: TAPS must be >= 2 and FRAC_SH >= 1");
  end

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                   state, state_nxt;
  logic signed [DATA_W-1:0] dline [TAPS];
  logic signed [COEF_W-1:0] coef  [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            idx;
  logic signed [PW-1:0]     prod;
  logic signed [RW-1:0]     rnd_sum;
  logic signed [RW-1:0]     rnd_val;
  logic                     clip_hi;
  logic                     clip_lo;
  logic                     coef_ok;

  assign in_ready = (state == IDLE);
  assign busy     = (state == MAC) || (state == DONE);
  assign coef_ok  = coef_we && ({1'b0, coef_addr} < TAPS_C);
  assign prod     = PW'(dline[idx]) * PW'(coef[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = MAC;
      MAC:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Round half up on the widened accumulator, then clip to the output range.
  always_comb begin
    rnd_sum = {acc[ACC_W-1], acc} + HALF;
    rnd_val = rnd_sum >>> FRAC_SH;
    clip_hi = (rnd_val > OUT_MAX);
    clip_lo = (rnd_val < OUT_MIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        dline[k] <= '0;
        coef[k]  <= '0;
      end
      acc       <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (coef_ok) coef[coef_addr] <= coef_wdata;
          if (in_valid) begin
            dline[0] <= in_data;
            for (int k = 1; k < TAPS; k++) dline[k] <= dline[k-1];
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        DONE: begin
          out_valid <= 1'b1;
          sat_flag  <= clip_hi | clip_lo;
          if (clip_hi)      out_data <= OUT_MAX[OUT_W-1:0];
          else if (clip_lo) out_data <= OUT_MIN[OUT_W-1:0];
          else              out_data <= rnd_val[OUT_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rrc_fir_serial.sv
// Directed bench for rrc_fir_serial: a reference model predicts each output on accept;
// a negedge monitor pops and compares data, saturation flag and latency.
module tb_rrc_fir_serial;
  localparam int DATA_W = 9;
  localparam int COEF_W = 9;
  localparam int TAPS   = 33;
  localparam int AW     = $clog2(TAPS);
  localparam int OUT_W  = 9;
  localparam longint LAT_T = 345;  // 34 edges * 10 plus half period to the sampling negedge

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     sat_flag;
  logic                     busy;

  rrc_fir_serial dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     d;
    bit     s;
    longint t;
  } exp_t;

  exp_t q[$];
  int   md[TAPS];
  int   mc[TAPS];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input int x);
    longint acc = 0;
    longint r;
    exp_t   e;
    for (int k = TAPS - 1; k > 0; k--) md[k] = md[k-1];
    md[0] = x;
    for (int k = 0; k < TAPS; k++) acc += longint'(md[k]) * longint'(mc[k]);
    r   = (acc + 128) >>> 8;
    e.s = (r > 255) || (r < -256);
    e.d = (r > 255) ? 255 : (r < -256) ? -256 : int'(r);
    e.t = $time;
    q.push_back(e);
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      md[k] = 0;
      mc[k] = 0;
    end
  endtask

  // Output monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data", $signed(out_data), e.d);
        check("sat_flag", sat_flag, e.s);
        check("latency", $time - e.t, LAT_T);
      end
    end
  end

  // All tasks begin and end just after a negedge.
  task automatic wcoef(input int a, input int v);
    coef_we    = 1'b1;
    coef_addr  = AW'(a);
    coef_wdata = COEF_W'(v);
    @(posedge clk);
    if (a < TAPS) mc[a] = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send(input int x, input bit cw = 1'b0, input int ca = 0, input int cd = 0);
    int w = 0;
    while (in_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("send_wait_in_ready", (w < 200), 1);
    in_valid   = 1'b1;
    in_data    = DATA_W'(x);
    coef_we    = cw;
    coef_addr  = AW'(ca);
    coef_wdata = COEF_W'(cd);
    @(posedge clk);
    if (cw && ca < TAPS) mc[ca] = cd;
    model_accept(x);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || in_ready !== 1'b1) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", (w < 100), 1);
  endtask

  task automatic load_impulse_coefs();
    for (int k = 0; k < TAPS; k++) wcoef(k, 4 * k - 64);
  endtask

  task automatic run_impulse();
    send(64);
    for (int n = 0; n < 40; n++) send(0);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    model_clear();

    // 1: reset state, zero coefficients
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    send(100);
    check("mac_busy", busy, 1);
    check("mac_in_ready", in_ready, 0);
    drain();

    // 2: impulse response through a ramp of coefficients
    load_impulse_coefs();
    run_impulse();

    // 3: rounding, dropped out-of-range write, same-edge write and sample
    for (int k = 0; k < TAPS; k++) wcoef(k, (k == 0) ? 1 : 0);
    send(128);
    send(127);
    send(-128);
    send(-129);
    drain();
    wcoef(40, 77);
    send(200, 1'b1, 0, 2);
    send(200);
    drain();

    // 4: saturation at both rails
    for (int k = 0; k < TAPS; k++) wcoef(k, 255);
    for (int n = 0; n < TAPS; n++) send(255);
    drain();
    check("sat_hi_data", $signed(out_data), 255);
    check("sat_hi_flag", sat_flag, 1);
    for (int n = 0; n < TAPS; n++) send(-256);
    drain();
    check("sat_lo_data", $signed(out_data), -256);
    check("sat_lo_flag", sat_flag, 1);

    // 5: held in_valid with a value that changes every cycle; coef writes while busy
    load_impulse_coefs();
    begin
      int     v       = 0;
      int     n_acc   = 0;
      int     low_cnt = 0;
      longint last_t  = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 4 * 35 + 5 && n_acc < 4; c++) begin
        in_data    = DATA_W'(v);
        coef_we    = (in_ready !== 1'b1);
        coef_addr  = AW'($urandom_range(0, TAPS - 1));
        coef_wdata = COEF_W'($urandom);
        if (in_ready === 1'b1) begin
          if (n_acc > 0) check("ready_low_cycles", low_cnt, 34);
          low_cnt = 0;
          @(posedge clk);
          model_accept(v);
          if (n_acc > 0) check("accept_spacing", $time - last_t, 350);
          last_t = $time;
          n_acc++;
        end else begin
          low_cnt++;
          @(posedge clk);
        end
        @(negedge clk);
        v++;
      end
      in_valid = 1'b0;
      coef_we  = 1'b0;
      check("accept_count", n_acc, 4);
    end
    drain();
    run_impulse();

    // 6: reset in the middle of MAC
    send(5);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", $signed(out_data), 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    check("midrst_quiet_data", $signed(out_data), 0);
    send(64);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
